multicycle_main_control: RTL



---
 rtl/multicycle_main_control_pkg.sv | 42 ++++
 rtl/multicycle_main_control.sv | 125 ++++++++++++
 2 files changed

// File: rtl/multicycle_main_control_pkg.sv
// Shared encodings for the multicycle MIPS main control FSM and the ALU decoder:
// opcodes, state numbers, ALUOp codes and datapath mux selects.
package multicycle_main_control_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9
  } state_e;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG      = 2'b00;
  localparam logic [1:0] SRCB_FOUR     = 2'b01;
  localparam logic [1:0] SRCB_IMM      = 2'b10;
  localparam logic [1:0] SRCB_IMM_SHL2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic is_legal_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ)   || (op == OP_J);
  endfunction

endpackage

// File: rtl/multicycle_main_control.sv
// Main control FSM for a multicycle MIPS datapath: one state register,
// next-state logic and a Moore-style strobe decode (FETCH also looks at mem_ready).
module multicycle_main_control
  import multicycle_main_control_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic [1:0] ALUOp,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       IRWrite,
  output logic [3:0] state,
  output logic       illegal_op
);

  state_e state_q, state_d;

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  assign state = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if ((opcode == OP_LW) || (opcode == OP_SW)) state_d = S_MEMADR;
        else if (opcode == OP_RTYPE)                state_d = S_EXEC;
        else if (opcode == OP_BEQ)                  state_d = S_BRANCH;
        else if (opcode == OP_J)                    state_d = S_JUMP;
        else                                        state_d = S_FETCH;
      end
      S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWR:  if (mem_ready) state_d = S_FETCH;
      S_EXEC:   state_d = S_ALUWB;
      default:  state_d = S_FETCH;
    endcase
  end

  // NOTE: every output gets a default before the case, so no path leaves a latch behind.
  always_comb begin
    ALUOp       = ALUOP_ADD;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_REG;
    PCSrc       = PCSRC_ALU;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    IRWrite     = 1'b0;
    illegal_op  = 1'b0;
    // Strobes are gated by rst_n so nothing fires while the reset is held,
    // even though the register already sits in FETCH.
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = SRCB_FOUR;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        S_DECODE: begin
          ALUSrcB    = SRCB_IMM_SHL2;
          illegal_op = !is_legal_op(opcode);
        end
        S_MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
        end
        S_MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        S_MEMWB: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
        end
        S_MEMWR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
        end
        S_EXEC: begin
          ALUSrcA = 1'b1;
          ALUOp   = ALUOP_FUNCT;
        end
        S_ALUWB: begin
          RegWrite = 1'b1;
          RegDst   = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = ALUOP_SUB;
          PCWriteCond = 1'b1;
          PCSrc       = PCSRC_ALUOUT;
        end
        S_JUMP: begin
          PCWrite = 1'b1;
          PCSrc   = PCSRC_JUMP;
        end
        default: ;
      endcase
    end
  end

endmodule
